mop_stream_accumulator: RTL and testbench
=========================================

Name: mop_stream_accumulator

Overview:
- Sequential counterpart to the combinational 8-operand adder tree: the same 8 x 7-bit operand sum, computed serially.
- Operands arrive one per cycle on a valid/ready stream; a group of N_OPS operands (or fewer, closed early by in_last) is accumulated, and the sum is presented on a valid/ready result port.
- Sits between operand producers and result consumers. It replaces the parallel tree where area matters, and serves as the golden cross-check for the tree in system benches.

Parameters:
- W, 7, operand width in bits.
- N_OPS, 8, maximum operands per group.
- CNT_W, $clog2(N_OPS+1) = 4, width of operand count.
- SUM_W, W+$clog2(N_OPS) = 10, result width; wide enough for N_OPS x (2^W-1), so overflow is impossible.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand present.
- in_ready  out  1  block can accept an operand this cycle.
- in_data  in  W  operand, unsigned.
- in_last  in  1  operand closes the group early.
- out_valid  out  1  result held.
- out_ready  in  1  consumer takes result.
- out_sum  out  SUM_W  group sum, unsigned.
- out_count  out  CNT_W  number of operands in the group (1..N_OPS).

Behaviour:
- Reset (rst=1 at posedge): state=ACCUM, acc=0, cnt=0, out_valid=0, out_sum=0, out_count=0, in_ready=1 in the following cycle. rst overrides all other inputs. A partially accumulated group is discarded. A held result is dropped without handshake.
- States: ACCUM (collecting operands) and HOLD (result valid, waiting for consumer).
- in_ready = (state==ACCUM) || (state==HOLD && out_ready). This is combinational on out_ready and registered everywhere else.
- Operand accept = in_valid && in_ready.
- ACCUM, accept, group not closing: acc <= acc + zero-extend(in_data); cnt <= cnt+1.
- ACCUM, accept, group closing (in_last=1 or cnt==N_OPS-1):
  - out_sum <= acc + in_data; out_count <= cnt+1;
  - acc <= 0; cnt <= 0;
  - out_valid <= 1; state -> HOLD.
- Latency: result is visible the cycle after the closing operand is accepted. Throughput is one operand per cycle.
- HOLD, out_ready=0: outputs stable, in_ready=0, no operand consumed.
- HOLD, out_ready=1, no accept: out_valid <= 0; state -> ACCUM.
- HOLD, out_ready=1 and accept (simultaneous consume and new operand):
  - The result is retired and the operand becomes the first of the next group (acc <= in_data, cnt <= 1).
  - If that operand also closes its group (in_last=1, or N_OPS==1), out_sum/out_count are reloaded, out_valid stays 1, and the state stays HOLD.
- in_valid=0 in ACCUM: no state change. Gaps between operands are allowed at any point.
- out_sum and out_count are registers that change only on group close or reset. They keep their last value after out_valid drops.
- All arithmetic is unsigned, and the accumulator is SUM_W wide, so it never wraps.
- in_last on the N_OPS-th operand is redundant and harmless. in_last is ignored when not accepted.

Decomposition:
- Shared package mop_pkg: MOP_W=7, MOP_N_OPS=8, MOP_SUM_W=10, and the state enum {ACCUM, HOLD}. The existing adder-tree bench imports the same constants.
- No sub-module. The datapath is a single adder plus a counter, and a separate module would only add wiring.

Test Plan:
- Stream 0,1,2,3,4,5,6,7 on consecutive cycles with out_ready=1 -> one cycle after the 8th accept, out_valid=1, out_sum=28, out_count=8; this matches the adder-tree result for the same operands.
- Stream eight operands of 1, then 3,1,2,4,5,6,7 with in_last on the 7th, out_ready=1 -> sums 8 (count 8) then 28 (count 7). Back-to-back groups show no bubble.
- Eight operands of 127 -> out_sum=1016, out_count=8; the full SUM_W range is reached with no wrap.
- Group 3,1,2,3,4,5,6,7 (sum 31) with out_ready held low for 5 cycles while in_valid stays high -> in_ready=0 and out_sum=31 stable throughout. On the out_ready rise, the pending operand is accepted in the same cycle as the result is consumed and becomes the first operand of the next group.
- Single operand 9 with in_last=1 -> out_sum=9, out_count=1. A further operand 5 with in_last=1, offered in the same cycle the result is consumed -> out_valid stays 1, out_sum=5.
- After 4 operands of 10, assert rst for 1 cycle -> out_valid=0, out_sum=0, in_ready=1. Then 8 operands of 2 -> out_sum=16, with no residue from the aborted group.

Source files
------------

// File: rtl/mop_pkg.sv
// Constants and state encoding shared by the serial accumulator and the parallel
// adder-tree benches.
package mop_pkg;
  localparam int MOP_W     = 7;
  localparam int MOP_N_OPS = 8;
  localparam int MOP_SUM_W = MOP_W + $clog2(MOP_N_OPS);
  localparam int MOP_CNT_W = $clog2(MOP_N_OPS + 1);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } mop_state_e;
endpackage

// File: rtl/mop_stream_accumulator.sv
// Serial 8-operand adder: sums up to N_OPS operands per group from a valid/ready
// stream and holds the sum on a valid/ready result port.
module mop_stream_accumulator
  import mop_pkg::*;
#(
  parameter int W     = MOP_W,
  parameter int N_OPS = MOP_N_OPS,
  parameter int CNT_W = $clog2(N_OPS + 1),
  parameter int SUM_W = W + $clog2(N_OPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic [CNT_W-1:0] out_count
);

  mop_state_e       state_q;
  logic [SUM_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] count_q;
  logic             valid_q;
  logic             accept, closing;

  // acc/cnt are cleared on every close, so an operand accepted while retiring a
  // result in HOLD naturally starts the next group from zero.
  assign in_ready = (state_q == ACCUM) || out_ready;
  assign accept   = in_valid && in_ready;
  assign acc_d    = acc_q + SUM_W'(in_data);
  assign cnt_d    = cnt_q + CNT_W'(1);
  assign closing  = in_last || (cnt_q == CNT_W'(N_OPS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (accept) begin
            if (closing) begin
              sum_q   <= acc_d;
              count_q <= cnt_d;
              acc_q   <= '0;
              cnt_q   <= '0;
              valid_q <= 1'b1;
              state_q <= HOLD;
            end else begin
              acc_q <= acc_d;
              cnt_q <= cnt_d;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            if (accept && closing) begin
              sum_q   <= acc_d;
              count_q <= cnt_d;
              acc_q   <= '0;
              cnt_q   <= '0;
            end else begin
              valid_q <= 1'b0;
              state_q <= ACCUM;
              if (accept) begin
                acc_q <= acc_d;
                cnt_q <= cnt_d;
              end
            end
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_count = count_q;

endmodule

// File: tb/tb_mop_stream_accumulator.sv
// Directed bench for mop_stream_accumulator with hand-computed expected sums.
module tb_mop_stream_accumulator;
  import mop_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 in_valid, in_ready, in_last;
  logic [MOP_W-1:0]     in_data;
  logic                 out_valid, out_ready;
  logic [MOP_SUM_W-1:0] out_sum;
  logic [MOP_CNT_W-1:0] out_count;

  int vectors = 0;
  int miscompares = 0;

  mop_stream_accumulator dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic v, input int s, input int c);
    chk({tag, ".valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".sum"},   32'(out_sum),   32'(s));
    chk({tag, ".count"}, 32'(out_count), 32'(c));
  endtask

  task automatic feed(input int d, input logic last);
    in_valid = 1'b1;
    in_data  = MOP_W'(d);
    in_last  = last;
    step();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int grp2 [7];
    int grp4 [8];
    grp2 = '{3, 1, 2, 4, 5, 6, 7};
    grp4 = '{3, 1, 2, 3, 4, 5, 6, 7};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    chk_out("reset", 1'b0, 0, 0);
    chk("reset.in_ready", 32'(in_ready), 32'd1);

    // 0..7 back to back
    for (int i = 0; i < 8; i++) begin
      if (i > 0) chk("t1.no_early_valid", 32'(out_valid), 32'd0);
      feed(i, 1'b0);
    end
    chk_out("t1", 1'b1, 28, 8);
    idle();
    chk_out("t1.retired", 1'b0, 28, 8);

    // eight 1s then a 7-operand group closed by in_last, no bubble
    for (int i = 0; i < 8; i++) feed(1, 1'b0);
    chk_out("t2.g1", 1'b1, 8, 8);
    chk("t2.in_ready_hold", 32'(in_ready), 32'd1);
    for (int i = 0; i < 7; i++) begin
      feed(grp2[i], i == 6);
      if (i == 0) chk_out("t2.g1_retired", 1'b0, 8, 8);
    end
    chk_out("t2.g2", 1'b1, 28, 7);
    idle();

    // full-range sum
    for (int i = 0; i < 8; i++) feed(127, 1'b0);
    chk_out("t3", 1'b1, 1016, 8);
    idle();

    // backpressure with a pending operand
    for (int i = 0; i < 8; i++) feed(grp4[i], 1'b0);
    chk_out("t4", 1'b1, 31, 8);
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 7'd9; in_last = 1'b0;
    #1;
    chk("t4.in_ready_low", 32'(in_ready), 32'd0);
    for (int i = 0; i < 5; i++) begin
      step();
      chk_out("t4.stall", 1'b1, 31, 8);
      chk("t4.stall_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    #1;
    chk("t4.in_ready_rise", 32'(in_ready), 32'd1);
    step();
    chk_out("t4.consumed", 1'b0, 31, 8);
    feed(1, 1'b1);
    chk_out("t4.next_group", 1'b1, 10, 2);
    idle();

    // single-operand groups, reload during consume
    feed(9, 1'b1);
    chk_out("t5.single", 1'b1, 9, 1);
    feed(5, 1'b1);
    chk_out("t5.reload", 1'b1, 5, 1);
    idle();
    chk_out("t5.retired", 1'b0, 5, 1);

    // aborted group, then clean restart with a gap
    for (int i = 0; i < 4; i++) feed(10, 1'b0);
    rst = 1'b1; in_valid = 1'b0;
    step();
    rst = 1'b0;
    chk_out("t6.reset", 1'b0, 0, 0);
    chk("t6.in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i == 4) begin
        idle(); idle();
        chk("t6.gap_no_valid", 32'(out_valid), 32'd0);
      end
      feed(2, 1'b0);
    end
    chk_out("t6", 1'b1, 16, 8);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
